// File: rtl/cd_pkg.sv
// cd_pkg: shared definitions for the Neo CD sector sequencer.
//   - cd_state_t : sequencer FSM states
//   - SECTOR_WORDS / LAST_WORD : payload size in 16-bit words
//   - FRAME_MAX / SEC_MAX / MIN_MAX : BCD wrap limits of an M:S:F position
//   - bcd_inc8() : single two-digit BCD increment without wrap handling
package cd_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        READY    = 3'd2,
        WAIT_CDC = 3'd3,
        RD       = 3'd4,
        WR       = 3'd5,
        DONE     = 3'd6,
        INC      = 3'd7
    } cd_state_t;

    localparam int          SECTOR_WORDS = 1024;
    localparam logic [9:0]  LAST_WORD    = 10'(SECTOR_WORDS - 1);

    localparam logic [7:0]  FRAME_MAX    = 8'h74;
    localparam logic [7:0]  SEC_MAX      = 8'h59;
    localparam logic [7:0]  MIN_MAX      = 8'h99;

    // Two-digit BCD +1; the caller handles wrap at its own limit.
    function automatic logic [7:0] bcd_inc8(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/cd_sector_seq_msf_bcd_inc.sv
// msf_bcd_inc: combinational BCD M:S:F incrementer.
//   msf_in  [23:0] : {M, S, F} current position, BCD
//   msf_out [23:0] : position + 1 frame; F wraps 74->00, S wraps 59->00,
//                    M wraps 99->00 with no further carry.
module msf_bcd_inc
    import cd_pkg::*;
(
    input  logic [23:0] msf_in,
    output logic [23:0] msf_out
);

    logic [7:0] m_s;
    logic [7:0] s_s;
    logic [7:0] f_s;

    assign m_s = msf_in[23:16];
    assign s_s = msf_in[15:8];
    assign f_s = msf_in[7:0];

    // Ripple the frame carry through seconds into minutes.
    always_comb begin
        msf_out = msf_in;
        if (f_s == FRAME_MAX) begin
            msf_out[7:0] = 8'h00;
            if (s_s == SEC_MAX) begin
                msf_out[15:8] = 8'h00;
                if (m_s == MIN_MAX) begin
                    msf_out[23:16] = 8'h00;
                end else begin
                    msf_out[23:16] = bcd_inc8(m_s);
                end
            end else begin
                msf_out[15:8] = bcd_inc8(s_s);
            end
        end else begin
            msf_out[7:0] = bcd_inc8(f_s);
        end
    end

endmodule

// File: rtl/cd_sector_seq.sv
// cd_sector_seq: sequences Neo CD sector delivery around the CDC model.
// Fetches a sector from the HPS into the cache (HPS_REQ/HPS_ACK), announces
// it with SECTOR_READY, copies 1024 words cache->sector buffer on DMA_REQ
// (DMA_DONE at the end) and steps the BCD MSF on NEXT_SECTOR_REQ.
// All logic runs on the falling edge of CLK_12M; nRESET is async active-low.
// Ports: PLAY_START/STOP control, START_M/S/F load value, MSF_M/S/F current
// position, HPS_REQ/HPS_ACK fetch handshake, SECTOR_READY/NEXT_SECTOR_REQ/
// DMA_REQ/DMA_DONE CDC handshake, CACHE_ADDR/CACHE_DATA cache read port,
// BUF_ADDR/BUF_DATA/BUF_WE/BUF_WAIT buffer write port, BUSY, ERROR.
// Build option: define CD_SEQ_TIMEOUT_EN to enable the HPS acknowledge
// watchdog (TIMEOUT_CYCLES cycles in REQ -> ERROR, back to IDLE).
module cd_sector_seq
    import cd_pkg::*;
#(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd12000000
) (
    input  logic        CLK_12M,
    input  logic        nRESET,
    input  logic        PLAY_START,
    input  logic        STOP,
    input  logic [7:0]  START_M,
    input  logic [7:0]  START_S,
    input  logic [7:0]  START_F,
    output logic [7:0]  MSF_M,
    output logic [7:0]  MSF_S,
    output logic [7:0]  MSF_F,
    output logic        HPS_REQ,
    input  logic        HPS_ACK,
    output logic        SECTOR_READY,
    input  logic        NEXT_SECTOR_REQ,
    input  logic        DMA_REQ,
    output logic        DMA_DONE,
    output logic [9:0]  CACHE_ADDR,
    input  logic [15:0] CACHE_DATA,
    output logic [9:0]  BUF_ADDR,
    output logic [15:0] BUF_DATA,
    output logic        BUF_WE,
    input  logic        BUF_WAIT,
    output logic        BUSY,
    output logic        ERROR
);

    cd_state_t   state_r;
    logic [23:0] msf_r;
    logic [23:0] msf_next_s;
    logic        pending_r;
    logic        hps_req_r;
    logic        sector_ready_r;
    logic        dma_done_r;
    logic [9:0]  cache_addr_r;   // doubles as the copy word index
    logic [9:0]  buf_addr_r;
    logic        buf_we_r;
    logic        busy_r;

`ifdef CD_SEQ_TIMEOUT_EN
    logic [23:0] to_cnt_r;
    logic        error_r;
    logic        timeout_s;
    assign timeout_s = (to_cnt_r == (TIMEOUT_CYCLES - 24'd1));
    assign ERROR     = error_r;
`else
    // No watchdog in this build; the parameter is still referenced so both
    // builds share one parameter list.
    assign ERROR = 1'b0 & (TIMEOUT_CYCLES != 24'd0);
`endif

    msf_bcd_inc u_msf_inc (
        .msf_in  (msf_r),
        .msf_out (msf_next_s)
    );

    // Sequencer FSM with all control outputs registered.
    always_ff @(negedge CLK_12M or negedge nRESET) begin
        if (!nRESET) begin
            state_r        <= IDLE;
            msf_r          <= 24'h000000;
            pending_r      <= 1'b0;
            hps_req_r      <= 1'b0;
            sector_ready_r <= 1'b0;
            dma_done_r     <= 1'b0;
            cache_addr_r   <= 10'd0;
            buf_addr_r     <= 10'd0;
            buf_we_r       <= 1'b0;
            busy_r         <= 1'b0;
`ifdef CD_SEQ_TIMEOUT_EN
            to_cnt_r       <= 24'd0;
            error_r        <= 1'b0;
`endif
        end else if (STOP) begin
            // STOP beats PLAY_START; MSF and ERROR are left as they are.
            state_r        <= IDLE;
            pending_r      <= 1'b0;
            hps_req_r      <= 1'b0;
            sector_ready_r <= 1'b0;
            dma_done_r     <= 1'b0;
            buf_we_r       <= 1'b0;
            busy_r         <= 1'b0;
        end else if (PLAY_START) begin
            state_r        <= REQ;
            msf_r          <= {START_M, START_S, START_F};
            pending_r      <= 1'b0;
            hps_req_r      <= 1'b1;
            sector_ready_r <= 1'b0;
            dma_done_r     <= 1'b0;
            buf_we_r       <= 1'b0;
            busy_r         <= 1'b1;
`ifdef CD_SEQ_TIMEOUT_EN
            to_cnt_r       <= 24'd0;
            error_r        <= 1'b0;
`endif
        end else begin
            sector_ready_r <= 1'b0;
            dma_done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    state_r <= IDLE;
                end
                REQ: begin
                    if (HPS_ACK) begin
                        hps_req_r      <= 1'b0;
                        sector_ready_r <= 1'b1;
                        state_r        <= READY;
                    end
`ifdef CD_SEQ_TIMEOUT_EN
                    else if (timeout_s) begin
                        hps_req_r <= 1'b0;
                        error_r   <= 1'b1;
                        busy_r    <= 1'b0;
                        state_r   <= IDLE;
                    end else begin
                        to_cnt_r <= to_cnt_r + 24'd1;
                    end
`endif
                end
                READY: begin
                    state_r <= WAIT_CDC;
                end
                WAIT_CDC: begin
                    // DMA wins a tie; the sector step is remembered.
                    if (DMA_REQ) begin
                        cache_addr_r <= 10'd0;
                        state_r      <= RD;
                        if (NEXT_SECTOR_REQ) begin
                            pending_r <= 1'b1;
                        end
                    end else if (NEXT_SECTOR_REQ) begin
                        state_r <= INC;
                    end
                end
                RD: begin
                    buf_we_r   <= 1'b1;
                    buf_addr_r <= cache_addr_r;
                    state_r    <= WR;
                    if (NEXT_SECTOR_REQ) begin
                        pending_r <= 1'b1;
                    end
                end
                WR: begin
                    if (NEXT_SECTOR_REQ) begin
                        pending_r <= 1'b1;
                    end
                    // Under BUF_WAIT the write is simply held; the cache
                    // address is unchanged so its data stays stable too.
                    if (!BUF_WAIT) begin
                        buf_we_r <= 1'b0;
                        if (cache_addr_r == LAST_WORD) begin
                            dma_done_r <= 1'b1;
                            state_r    <= DONE;
                        end else begin
                            cache_addr_r <= cache_addr_r + 10'd1;
                            state_r      <= RD;
                        end
                    end
                end
                DONE: begin
                    if (pending_r) begin
                        pending_r <= 1'b0;
                        state_r   <= INC;
                    end else begin
                        state_r <= WAIT_CDC;
                    end
                end
                INC: begin
                    msf_r     <= msf_next_s;
                    hps_req_r <= 1'b1;
                    state_r   <= REQ;
`ifdef CD_SEQ_TIMEOUT_EN
                    to_cnt_r  <= 24'd0;
`endif
                end
                default: begin
                    state_r   <= IDLE;
                    hps_req_r <= 1'b0;
                    buf_we_r  <= 1'b0;
                    busy_r    <= 1'b0;
                end
            endcase
        end
    end

    assign MSF_M        = msf_r[23:16];
    assign MSF_S        = msf_r[15:8];
    assign MSF_F        = msf_r[7:0];
    assign HPS_REQ      = hps_req_r;
    assign SECTOR_READY = sector_ready_r;
    assign DMA_DONE     = dma_done_r;
    assign CACHE_ADDR   = cache_addr_r;
    assign BUF_ADDR     = buf_addr_r;
    assign BUF_WE       = buf_we_r;
    assign BUSY         = busy_r;
    // Cache data arrives during the write cycle itself; gating by the strobe
    // keeps the bus at zero whenever no write is in progress.
    assign BUF_DATA     = buf_we_r ? CACHE_DATA : 16'h0000;

endmodule

// File: tb/tb_cd_sector_seq.sv
// Self-checking bench for cd_sector_seq: directed steps in one initial block,
// with a scoreboard of expected buffer writes checked by a write monitor.
module tb_cd_sector_seq;

    logic        CLK_12M = 1'b0;
    logic        nRESET = 1'b0;
    logic        PLAY_START = 1'b0;
    logic        STOP = 1'b0;
    logic [7:0]  START_M = 8'h00;
    logic [7:0]  START_S = 8'h00;
    logic [7:0]  START_F = 8'h00;
    logic [7:0]  MSF_M, MSF_S, MSF_F;
    logic        HPS_REQ;
    logic        HPS_ACK = 1'b0;
    logic        SECTOR_READY;
    logic        NEXT_SECTOR_REQ = 1'b0;
    logic        DMA_REQ = 1'b0;
    logic        DMA_DONE;
    logic [9:0]  CACHE_ADDR;
    logic [15:0] CACHE_DATA;
    logic [9:0]  BUF_ADDR;
    logic [15:0] BUF_DATA;
    logic        BUF_WE;
    logic        BUF_WAIT = 1'b0;
    logic        BUSY;
    logic        ERROR;

    logic [15:0] cache_q = 16'h0000;

    typedef struct packed {
        logic [9:0]  a;
        logic [15:0] d;
    } exp_t;
    exp_t sb_q[$];

    int passed = 0;
    int total = 0;
    int failed = 0;
    int wr_count = 0;
    int w5_cycles = 0;
    int done_count = 0;

    cd_sector_seq #(.TIMEOUT_CYCLES(24'd100)) dut (
        .CLK_12M(CLK_12M), .nRESET(nRESET), .PLAY_START(PLAY_START), .STOP(STOP),
        .START_M(START_M), .START_S(START_S), .START_F(START_F),
        .MSF_M(MSF_M), .MSF_S(MSF_S), .MSF_F(MSF_F),
        .HPS_REQ(HPS_REQ), .HPS_ACK(HPS_ACK), .SECTOR_READY(SECTOR_READY),
        .NEXT_SECTOR_REQ(NEXT_SECTOR_REQ), .DMA_REQ(DMA_REQ), .DMA_DONE(DMA_DONE),
        .CACHE_ADDR(CACHE_ADDR), .CACHE_DATA(CACHE_DATA),
        .BUF_ADDR(BUF_ADDR), .BUF_DATA(BUF_DATA), .BUF_WE(BUF_WE), .BUF_WAIT(BUF_WAIT),
        .BUSY(BUSY), .ERROR(ERROR)
    );

    always #5 CLK_12M = ~CLK_12M;

    // Cache model: word k holds A500+k, registered read on the DUT clock edge.
    always @(negedge CLK_12M) cache_q <= 16'hA500 + {6'd0, CACHE_ADDR};
    assign CACHE_DATA = cache_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Write monitor: every accepted write pops and checks the scoreboard.
    always @(posedge CLK_12M) begin
        exp_t e;
        #2;
        if (nRESET && BUF_WE) begin
            if (BUF_ADDR == 10'd5) w5_cycles++;
            if (!BUF_WAIT) begin
                wr_count++;
                check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check("buf_addr", 32'(BUF_ADDR), 32'(e.a));
                    check("buf_data", 32'(BUF_DATA), 32'(e.d));
                end
            end
        end
        if (nRESET && DMA_DONE) done_count++;
    end

    // 0 PLAY_START, 1 HPS_ACK, 2 NEXT_SECTOR_REQ, 3 DMA_REQ; returns #1 after
    // the edge that sampled the pulse.
    task automatic pulse(input int which);
        @(posedge CLK_12M);
        case (which)
            0: PLAY_START = 1'b1;
            1: HPS_ACK = 1'b1;
            2: NEXT_SECTOR_REQ = 1'b1;
            default: DMA_REQ = 1'b1;
        endcase
        @(posedge CLK_12M);
        PLAY_START = 1'b0;
        HPS_ACK = 1'b0;
        NEXT_SECTOR_REQ = 1'b0;
        DMA_REQ = 1'b0;
        #1;
    endtask

    task automatic start_at(input logic [23:0] msf);
        {START_M, START_S, START_F} = msf;
        pulse(0);
    endtask

    task automatic push_sector();
        for (int k = 0; k < 1024; k++) begin
            sb_q.push_back({10'(k), 16'hA500 + 16'(k)});
        end
    endtask

    // Full copy; returns the number of DUT edges from the DMA_REQ sample to
    // the edge that raises DMA_DONE. Optionally stalls word 5.
    task automatic run_dma(input bit with_next, input int w5_waits, output int n);
        int waits_left;
        bit got;
        waits_left = w5_waits;
        got = 1'b0;
        wr_count = 0;
        w5_cycles = 0;
        done_count = 0;
        @(posedge CLK_12M);
        DMA_REQ = 1'b1;
        NEXT_SECTOR_REQ = with_next;
        push_sector();
        @(negedge CLK_12M);
        n = 0;
        while (n < 3000 && !got) begin
            @(negedge CLK_12M);
            n++;
            @(posedge CLK_12M);
            DMA_REQ = 1'b0;
            NEXT_SECTOR_REQ = 1'b0;
            #1;
            if (BUF_WE && BUF_ADDR == 10'd5 && waits_left > 0) begin
                BUF_WAIT = 1'b1;
                waits_left--;
            end else begin
                BUF_WAIT = 1'b0;
            end
            if (DMA_DONE) got = 1'b1;
        end
        BUF_WAIT = 1'b0;
        check("dma_done_seen", 32'(got), 32'd1);
    endtask

    initial begin
        int n;

        // Reset state
        #1;
        check("rst_msf", {8'h00, MSF_M, MSF_S, MSF_F}, 32'h0);
        check("rst_hps_req", 32'(HPS_REQ), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_buf_we", 32'(BUF_WE), 32'd0);
        check("rst_error", 32'(ERROR), 32'd0);
        repeat (3) @(posedge CLK_12M);
        nRESET = 1'b1;

        // Start at 00:59:74, fetch, step -> 01:00:00
        start_at(24'h005974);
        check("play_hps_req", 32'(HPS_REQ), 32'd1);
        check("play_msf", {8'h00, MSF_M, MSF_S, MSF_F}, 32'h005974);
        check("play_busy", 32'(BUSY), 32'd1);
        pulse(1);
        check("ack_sector_ready", 32'(SECTOR_READY), 32'd1);
        check("ack_hps_req", 32'(HPS_REQ), 32'd0);
        @(posedge CLK_12M); #1;
        check("sector_ready_pulse", 32'(SECTOR_READY), 32'd0);
        pulse(2);
        check("inc_hps_req_low", 32'(HPS_REQ), 32'd0);
        @(posedge CLK_12M); #1;
        check("inc_hps_req", 32'(HPS_REQ), 32'd1);
        check("inc_msf", {8'h00, MSF_M, MSF_S, MSF_F}, 32'h010000);

        // DMA with three wait cycles on word 5
        pulse(1);
        @(posedge CLK_12M); #1;
        run_dma(1'b0, 3, n);
        check("dma_latency_wait", 32'(n), 32'd2051);
        @(posedge CLK_12M); #3;
        check("dma_writes", 32'(wr_count), 32'd1024);
        check("dma_w5_cycles", 32'(w5_cycles), 32'd4);
        check("dma_sb_empty", 32'(sb_q.size()), 32'd0);
        check("dma_done_once", 32'(done_count), 32'd1);
        check("dma_after_busy", 32'(BUSY), 32'd1);
        check("dma_after_hps_req", 32'(HPS_REQ), 32'd0);
        check("dma_after_msf", {8'h00, MSF_M, MSF_S, MSF_F}, 32'h010000);

        // DMA_REQ and NEXT_SECTOR_REQ together: copy, DONE, INC, REQ
        run_dma(1'b1, 0, n);
        check("dma_latency", 32'(n), 32'd2048);
        @(posedge CLK_12M); #1;
        check("pend_inc_hps_req_low", 32'(HPS_REQ), 32'd0);
        @(posedge CLK_12M); #1;
        check("pend_hps_req", 32'(HPS_REQ), 32'd1);
        check("pend_msf", {8'h00, MSF_M, MSF_S, MSF_F}, 32'h010001);
        check("pend_writes", 32'(wr_count), 32'd1024);
        check("pend_sb_empty", 32'(sb_q.size()), 32'd0);

        // STOP during the write of word 300
        pulse(1);
        @(posedge CLK_12M);
        DMA_REQ = 1'b1;
        push_sector();
        done_count = 0;
        @(posedge CLK_12M);
        DMA_REQ = 1'b0;
        n = 0;
        #1;
        while (n < 2000 && !(BUF_WE && BUF_ADDR == 10'd300)) begin
            @(posedge CLK_12M); #1;
            n++;
        end
        check("stop_reached_w300", 32'(BUF_WE && BUF_ADDR == 10'd300), 32'd1);
        STOP = 1'b1;
        @(posedge CLK_12M);
        STOP = 1'b0;
        #1;
        check("stop_buf_we", 32'(BUF_WE), 32'd0);
        check("stop_busy", 32'(BUSY), 32'd0);
        check("stop_hps_req", 32'(HPS_REQ), 32'd0);
        repeat (10) @(posedge CLK_12M);
        #3;
        check("stop_no_done", 32'(done_count), 32'd0);
        check("stop_msf", {8'h00, MSF_M, MSF_S, MSF_F}, 32'h010001);
        sb_q.delete();

        // Wrap 99:59:74 -> 00:00:00
        start_at(24'h995974);
        pulse(1);
        @(posedge CLK_12M); #1;
        pulse(2);
        @(posedge CLK_12M); #1;
        check("wrap_hps_req", 32'(HPS_REQ), 32'd1);
        check("wrap_msf", {8'h00, MSF_M, MSF_S, MSF_F}, 32'h000000);

`ifdef CD_SEQ_TIMEOUT_EN
        // Watchdog: 100 cycles in REQ without acknowledge
        @(posedge CLK_12M);
        PLAY_START = 1'b1;
        @(negedge CLK_12M);
        @(posedge CLK_12M);
        PLAY_START = 1'b0;
        #1;
        n = 0;
        while (n < 1000 && !ERROR) begin
            @(negedge CLK_12M);
            n++;
            @(posedge CLK_12M); #1;
        end
        check("to_cycles", 32'(n), 32'd100);
        check("to_error", 32'(ERROR), 32'd1);
        check("to_hps_req", 32'(HPS_REQ), 32'd0);
        check("to_busy", 32'(BUSY), 32'd0);
        start_at(24'h000000);
        check("to_clear_error", 32'(ERROR), 32'd0);
        check("to_restart_hps_req", 32'(HPS_REQ), 32'd1);
`else
        // No watchdog: REQ waits indefinitely
        repeat (150) @(posedge CLK_12M);
        #1;
        check("nto_error", 32'(ERROR), 32'd0);
        check("nto_hps_req", 32'(HPS_REQ), 32'd1);
        check("nto_busy", 32'(BUSY), 32'd1);
`endif

        // Asynchronous reset in the middle of a copy
        start_at(24'h000010);
        pulse(1);
        @(posedge CLK_12M);
        DMA_REQ = 1'b1;
        push_sector();
        @(posedge CLK_12M);
        DMA_REQ = 1'b0;
        repeat (20) @(posedge CLK_12M);
        #3;
        nRESET = 1'b0;
        #1;
        check("arst_buf_we", 32'(BUF_WE), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_msf", {8'h00, MSF_M, MSF_S, MSF_F}, 32'h0);
        check("arst_buf_addr", 32'(BUF_ADDR), 32'd0);
        check("arst_cache_addr", 32'(CACHE_ADDR), 32'd0);
        check("arst_buf_data", 32'(BUF_DATA), 32'd0);
        @(posedge CLK_12M);
        nRESET = 1'b1;
        sb_q.delete();
        repeat (2) @(posedge CLK_12M);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
